tx_stream_reader: RTL and testbench
===================================

TX_STREAM_READER -- requirements
Module: tx_stream_reader

Interface
REQ-001 The block SHALL have parameter PARAM_MEM_LATENCY, default 5, equal to the cycles from a MEM_ADDR value being driven to its word appearing on MEM_Q.
REQ-002 The block SHALL have parameter PARAM_FIFO_DEPTH, default 8, the output buffer depth; legal only if ≥ PARAM_MEM_LATENCY+1 and a power of two.
REQ-003 The block SHALL run on one clock with a synchronous, active-high reset, named as follows.
REQ-004 The block SHALL have port MEM_CLK, input, 1 bit: the single clock, the same MEM_CLK as the dual-pumped TX memory.
REQ-005 The block SHALL have port MEM_RESET, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port START, input, 1 bit: single-cycle request to begin a burst.
REQ-007 The block SHALL have port BASE_ADDR, input, 9 bits: first word address, sampled with START.
REQ-008 The block SHALL have port LENGTH, input, 10 bits: word count 0..512, sampled with START.
REQ-009 The block SHALL have port BUSY, output, 1 bit: burst in progress.
REQ-010 The block SHALL have port DONE, output, 1 bit: single-cycle burst-complete pulse.
REQ-011 The block SHALL have port MEM_ADDR, output, 9 bits: registered read address to the TX memory raw port.
REQ-012 The block SHALL have port MEM_Q, input, 32 bits: read data from the TX memory.
REQ-013 The block SHALL have port OUT_DATA, output, 32 bits: head word of the stream.
REQ-014 The block SHALL have port OUT_VALID, output, 1 bit: OUT_DATA holds a valid word.
REQ-015 The block SHALL have port OUT_READY, input, 1 bit: the consumer accepts the word; a transfer occurs when OUT_VALID and OUT_READY are both high.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, DRAIN and FIN; BUSY is high in ISSUE and DRAIN.
REQ-017 In IDLE, START with LENGTH≠0 SHALL latch BASE_ADDR and LENGTH and go to ISSUE.
REQ-018 In IDLE, START with LENGTH=0 SHALL go to FIN with no memory reads.
REQ-019 START outside IDLE SHALL be ignored.
REQ-020 In ISSUE, one address SHALL be issued per cycle only while (inflight + fifo_count) < PARAM_FIFO_DEPTH (credit rule); otherwise MEM_ADDR holds and no read is counted.
REQ-021 Issued addresses SHALL be BASE_ADDR, BASE_ADDR+1, ... modulo 512, so 511 wraps to 0.
REQ-022 After the LENGTH-th issue the FSM SHALL go to DRAIN.
REQ-023 inflight SHALL be tracked by a PARAM_MEM_LATENCY-deep valid shift register; a valid bit exiting it SHALL write MEM_Q into the FIFO in that cycle.
REQ-024 The memory pipeline cannot stall, so by the credit rule the FIFO SHALL never overflow; an overflow is a design error and SHALL fire an assertion.
REQ-025 The FIFO SHALL be first-word-fall-through: OUT_VALID = fifo not empty, OUT_DATA = head word.
REQ-026 A simultaneous FIFO write and read SHALL keep fifo_count unchanged.
REQ-027 Latency: START accepted at cycle 0 → MEM_ADDR=BASE at cycle 1 → first OUT_VALID at cycle PARAM_MEM_LATENCY+2.
REQ-028 With OUT_READY held high, the block SHALL sustain one word per cycle.
REQ-029 In DRAIN, the FSM SHALL go to FIN in the cycle the LENGTH-th word transfers.
REQ-030 FIN SHALL assert DONE for one cycle and return to IDLE; START is accepted again from the next cycle.
REQ-031 Words SHALL emerge in address order, with none duplicated or dropped.

Reset
REQ-032 On MEM_RESET the block SHALL reset to state IDLE, with BUSY=0, DONE=0, OUT_VALID=0, MEM_ADDR=0, fifo_count=0, the inflight register cleared and OUT_DATA=0.
REQ-033 Reset mid-burst SHALL abort the burst: in-flight MEM_Q returns are discarded, and no DONE is produced.

Structure
REQ-034 A shared package tx_stream_pkg SHALL hold the FSM state enum, MEM_AW=9, MEM_DW=32 and LEN_W=10.
REQ-035 The FIFO SHALL be the sub-module tx_stream_fifo, a synchronous FWFT FIFO with parameterised depth and width and count output.

Verification
REQ-036 The bench SHALL cover: BASE=0, LENGTH=4, OUT_READY=1 → MEM_ADDR 0,1,2,3 on cycles 1-4; OUT_DATA = mem[0..3] on cycles 7-10; DONE at cycle 11.
REQ-037 The bench SHALL cover: BASE=510, LENGTH=4 → MEM_ADDR 510,511,0,1; output order mem[510],mem[511],mem[0],mem[1].
REQ-038 The bench SHALL cover: LENGTH=512 with OUT_READY low after START → exactly 8 addresses are issued, the stream stalls with fifo_count=8 and no overflow; after release all 512 words arrive in order with one DONE.
REQ-039 The bench SHALL cover: LENGTH=0 → DONE on cycle 1, BUSY stays 0, and no MEM_ADDR change.
REQ-040 The bench SHALL cover: START reasserted mid-burst with BASE=100 → ignored, and the original sequence completes unchanged.
REQ-041 The bench SHALL cover: MEM_RESET at cycle 3 of a LENGTH=20 burst → the next cycle shows IDLE, OUT_VALID=0 and no DONE; a new burst BASE=7, LENGTH=2 then returns mem[7], mem[8] correctly.

Source files
------------

// File: rtl/tx_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tx_stream_pkg
// Brief    : Shared widths and FSM state encoding for the TX stream reader.
// Revision : 1.0 - initial release
// ============================================================================
package tx_stream_pkg;

    localparam int MEM_AW = 9;   // TX memory word address width (512 words)
    localparam int MEM_DW = 32;  // TX memory word width
    localparam int LEN_W  = 10;  // burst length width, 0..512

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

endpackage : tx_stream_pkg
`default_nettype wire

// File: rtl/tx_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tx_stream_fifo
// Brief    : Synchronous first-word-fall-through FIFO with occupancy count.
//            Head word is visible on rd_data whenever the FIFO is not empty.
// Revision : 1.0 - initial release
// ============================================================================
module tx_stream_fifo #(
    parameter int DEPTH = 8,     // must be a power of two
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_rd   = rd_en && !empty;
    // A write into a full FIFO is only legal when the head is leaving this cycle.
    assign do_wr   = wr_en && (!full || do_rd);
    // Drive zero when empty so the output never shows stale or uninitialised data.
    assign rd_data = empty ? '0 : storage[rd_ptr];

    // Data storage: written only, never reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            storage[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; simultaneous write and read leaves count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_wr, do_rd})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // The upstream credit scheme must never push into a full FIFO.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(wr_en && full && !rd_en))
        else $error("tx_stream_fifo overflow");

endmodule : tx_stream_fifo
`default_nettype wire

// File: rtl/tx_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tx_stream_reader
// Brief    : Reads a burst of words from the fixed-latency TX memory and
//            presents them as a valid/ready stream. Reads are throttled by a
//            credit count so every word in flight has a guaranteed FIFO slot.
// Revision : 1.0 - initial release
// ============================================================================
module tx_stream_reader
    import tx_stream_pkg::*;
#(
    parameter int PARAM_MEM_LATENCY = 5,
    parameter int PARAM_FIFO_DEPTH  = 8
) (
    input  logic              MEM_CLK,
    input  logic              MEM_RESET,
    input  logic              START,
    input  logic [MEM_AW-1:0] BASE_ADDR,
    input  logic [LEN_W-1:0]  LENGTH,
    output logic              BUSY,
    output logic              DONE,
    output logic [MEM_AW-1:0] MEM_ADDR,
    input  logic [MEM_DW-1:0] MEM_Q,
    output logic [MEM_DW-1:0] OUT_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY
);

    localparam int CNT_W = $clog2(PARAM_FIFO_DEPTH + PARAM_MEM_LATENCY + 2) + 1;
    localparam int FC_W  = $clog2(PARAM_FIFO_DEPTH) + 1;

    state_t                       state;
    state_t                       state_next;
    logic [LEN_W-1:0]             length_q;
    logic [LEN_W-1:0]             issue_cnt;   // addresses loaded into MEM_ADDR
    logic [LEN_W-1:0]             xfer_cnt;    // words accepted by the consumer
    logic                         addr_vld;    // MEM_ADDR holds a freshly issued read
    logic [PARAM_MEM_LATENCY-1:0] lat_sr;      // one bit per memory pipeline cycle
    logic [CNT_W-1:0]             inflight;
    logic [FC_W-1:0]              fifo_count;
    logic                         fifo_empty;
    logic                         credit;
    logic                         start_ok;
    logic                         issue;
    logic                         xfer;

    assign start_ok  = (state == IDLE) && START && (LENGTH != '0);
    assign xfer      = OUT_VALID && OUT_READY;
    assign OUT_VALID = !fifo_empty;
    assign BUSY      = (state == ISSUE) || (state == DRAIN);
    assign DONE      = (state == FIN);

    // Count reads that have been issued but not yet landed in the FIFO.
    always_comb begin
        inflight = CNT_W'(addr_vld);
        for (int i = 0; i < PARAM_MEM_LATENCY; i++) begin
            inflight = inflight + CNT_W'(lat_sr[i]);
        end
    end

    // Only issue while every outstanding read still has a reserved FIFO slot.
    assign credit = (inflight + CNT_W'(fifo_count)) < CNT_W'(PARAM_FIFO_DEPTH);
    assign issue  = start_ok || ((state == ISSUE) && credit);

    // FSM state register.
    always_ff @(posedge MEM_CLK) begin
        if (MEM_RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (START) begin
                    if (LENGTH == '0) begin
                        state_next = FIN;
                    end else if (LENGTH == LEN_W'(1)) begin
                        state_next = DRAIN;
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (credit && (issue_cnt == length_q - LEN_W'(1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (xfer && (xfer_cnt == length_q - LEN_W'(1))) begin
                    state_next = FIN;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Burst bookkeeping and the registered read address (wraps modulo 512).
    always_ff @(posedge MEM_CLK) begin
        if (MEM_RESET) begin
            MEM_ADDR  <= '0;
            length_q  <= '0;
            issue_cnt <= '0;
            xfer_cnt  <= '0;
            addr_vld  <= 1'b0;
        end else begin
            addr_vld <= issue;
            if (start_ok) begin
                MEM_ADDR  <= BASE_ADDR;
                length_q  <= LENGTH;
                issue_cnt <= LEN_W'(1);
                xfer_cnt  <= '0;
            end else begin
                if ((state == ISSUE) && credit) begin
                    MEM_ADDR  <= MEM_ADDR + MEM_AW'(1);
                    issue_cnt <= issue_cnt + LEN_W'(1);
                end
                if (xfer) begin
                    xfer_cnt <= xfer_cnt + LEN_W'(1);
                end
            end
        end
    end

    // Valid tracker that mirrors the memory pipeline; its last stage marks MEM_Q valid.
    generate
        if (PARAM_MEM_LATENCY == 1) begin : g_lat_single
            always_ff @(posedge MEM_CLK) begin
                if (MEM_RESET) begin
                    lat_sr <= '0;
                end else begin
                    lat_sr <= addr_vld;
                end
            end
        end else begin : g_lat_multi
            always_ff @(posedge MEM_CLK) begin
                if (MEM_RESET) begin
                    lat_sr <= '0;
                end else begin
                    lat_sr <= {lat_sr[PARAM_MEM_LATENCY-2:0], addr_vld};
                end
            end
        end
    endgenerate

    tx_stream_fifo #(
        .DEPTH (PARAM_FIFO_DEPTH),
        .WIDTH (MEM_DW)
    ) u_fifo (
        .clk     (MEM_CLK),
        .rst     (MEM_RESET),
        .wr_en   (lat_sr[PARAM_MEM_LATENCY-1]),
        .wr_data (MEM_Q),
        .rd_en   (xfer),
        .rd_data (OUT_DATA),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // The buffer must hold a full memory pipeline plus one and be a power of two.
    a_param_legal : assert property (@(posedge MEM_CLK)
        (PARAM_FIFO_DEPTH >= PARAM_MEM_LATENCY + 1) &&
        ((PARAM_FIFO_DEPTH & (PARAM_FIFO_DEPTH - 1)) == 0))
        else $error("tx_stream_reader illegal FIFO depth");

endmodule : tx_stream_reader
`default_nettype wire

// File: tb/tb_tx_stream_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tx_stream_reader
// Brief    : Self-checking bench: directed vector table, hand-written stall,
//            reset and restart sequences, and randomized bursts checked
//            against an address-order stream model of the memory contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_stream_reader;

    localparam int LAT   = 5;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [8:0]  base_addr;
    logic [9:0]  length;
    logic        busy;
    logic        done;
    logic [8:0]  mem_addr;
    logic [31:0] mem_q;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    always #5 clk = ~clk;

    tx_stream_reader #(
        .PARAM_MEM_LATENCY (LAT),
        .PARAM_FIFO_DEPTH  (DEPTH)
    ) dut (
        .MEM_CLK   (clk),
        .MEM_RESET (rst),
        .START     (start),
        .BASE_ADDR (base_addr),
        .LENGTH    (length),
        .BUSY      (busy),
        .DONE      (done),
        .MEM_ADDR  (mem_addr),
        .MEM_Q     (mem_q),
        .OUT_DATA  (out_data),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready)
    );

    // Fixed-latency memory: the word for an address driven in cycle c shows in cycle c+LAT.
    logic [31:0] mem_arr [512];
    logic [8:0]  pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= mem_addr;
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_q = mem_arr[pipe[LAT-1]];

    int n_checks = 0;
    int n_fail   = 0;

    // Per-burst observations.
    int first_valid, done_cyc, ndone, nwords, busy_cycles, busy_after, valid_after_rst;
    int addr_tr  [64];
    int cnt_tr   [64];
    int busy_tr  [64];
    int valid_tr [64];
    int done_tr  [64];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Run one burst; cycle 0 is the cycle START is high.
    task automatic run_burst(input logic [8:0] b, input int len, input int pct,
                             input int release_at, input int restart_at,
                             input int reset_at, input int budget);
        logic [8:0] idx;
        first_valid = -1; done_cyc = -1; ndone = 0; nwords = 0;
        busy_cycles = 0; busy_after = 0; valid_after_rst = 0;
        for (int i = 0; i < 64; i++) begin
            addr_tr[i] = -1; cnt_tr[i] = -1; busy_tr[i] = -1; valid_tr[i] = -1; done_tr[i] = -1;
        end
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; length = 10'(len); out_ready = 1'b0;
        @(negedge clk);
        addr_tr[0] = mem_addr;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(posedge clk); #1;
            start = (cyc == restart_at);
            if (cyc == restart_at) begin
                base_addr = 9'd100;
                length    = 10'd7;
            end
            rst       = (cyc == reset_at);
            out_ready = (cyc >= release_at) && ($urandom_range(99) < pct);
            @(negedge clk);
            if (cyc < 64) begin
                addr_tr[cyc] = mem_addr; cnt_tr[cyc] = dut.fifo_count;
                busy_tr[cyc] = busy; valid_tr[cyc] = out_valid; done_tr[cyc] = done;
            end
            if (busy) busy_cycles++;
            if (done_cyc >= 0 && busy) busy_after++;
            if (reset_at > 0 && cyc > reset_at && out_valid) valid_after_rst++;
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (out_valid && out_ready) begin
                if (nwords < len) begin
                    idx = b + 9'(nwords);
                    check("word", out_data, mem_arr[idx]);
                end else begin
                    check("extra_word", nwords, len);
                end
                nwords++;
            end
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end
        start = 1'b0; rst = 1'b0; out_ready = 1'b0;
        if (reset_at == 0) check("completed_in_budget", done_cyc >= 0, 1);
    endtask

    typedef struct {
        logic [8:0] base;
        int         len;
        int         restart_at;
    } vec_t;

    vec_t vecs [7];
    int   exp_last_addr;

    initial begin
        for (int i = 0; i < 512; i++) mem_arr[i] = $urandom;
        for (int k = 0; k < LAT; k++) pipe[k] = '0;
        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_valid", out_valid, 0);
        check("reset_addr", mem_addr, 0);
        check("reset_data", out_data, 0);
        check("reset_fifo_count", dut.fifo_count, 0);
        @(posedge clk); #1 rst = 1'b0;
        exp_last_addr = 0;

        // Directed bursts with the consumer always ready.
        vecs[0] = '{9'd0,   4,  0};
        vecs[1] = '{9'd510, 4,  0};
        vecs[2] = '{9'd0,   0,  0};
        vecs[3] = '{9'd3,   1,  0};
        vecs[4] = '{9'd0,   12, 3};
        vecs[5] = '{9'd300, 16, 0};
        vecs[6] = '{9'd511, 2,  0};
        for (int v = 0; v < 7; v++) begin
            int         len;
            int         nchk;
            logic [8:0] ea;
            len = vecs[v].len;
            run_burst(vecs[v].base, len, 100, 0, vecs[v].restart_at, 0, 200);
            check("first_valid_cycle", first_valid, (len != 0) ? LAT + 2 : -1);
            check("done_cycle", done_cyc, (len != 0) ? LAT + 2 + len : 1);
            check("done_pulses", ndone, 1);
            check("word_count", nwords, len);
            check("busy_cycles", busy_cycles, (len != 0) ? LAT + 1 + len : 0);
            check("busy_after_done", busy_after, 0);
            if (len == 0) begin
                check("len0_addr_c1", addr_tr[1], exp_last_addr);
                check("len0_addr_c3", addr_tr[3], exp_last_addr);
            end else begin
                nchk = (len < 8) ? len : 8;
                for (int c = 1; c <= nchk; c++) begin
                    ea = vecs[v].base + 9'(c - 1);
                    check("issue_addr", addr_tr[c], ea);
                end
                ea = vecs[v].base + 9'(len - 1);
                if (len + 2 < 64) check("addr_hold", addr_tr[len + 2], ea);
                exp_last_addr = ea;
            end
        end

        // Full-length burst with the consumer stalled until cycle 40.
        run_burst(9'd0, 512, 100, 40, 0, 0, 1500);
        check("stall_addr_c8", addr_tr[8], 7);
        check("stall_addr_c39", addr_tr[39], 7);
        check("stall_fifo_count", cnt_tr[39], DEPTH);
        check("stall_valid", valid_tr[39], 1);
        check("stall_busy", busy_tr[39], 1);
        check("stall_first_valid", first_valid, LAT + 2);
        check("stall_word_count", nwords, 512);
        check("stall_done_pulses", ndone, 1);
        exp_last_addr = 511;

        // Reset in cycle 3 of a 20-word burst aborts it.
        run_burst(9'd50, 20, 100, 0, 0, 3, 20);
        check("rst_busy_c4", busy_tr[4], 0);
        check("rst_valid_c4", valid_tr[4], 0);
        check("rst_done_c4", done_tr[4], 0);
        check("rst_addr_c4", addr_tr[4], 0);
        check("rst_no_done", ndone, 0);
        check("rst_returns_dropped", valid_after_rst, 0);
        run_burst(9'd7, 2, 100, 0, 0, 0, 100);
        check("post_rst_words", nwords, 2);
        check("post_rst_first_valid", first_valid, LAT + 2);
        check("post_rst_done", done_cyc, LAT + 4);
        check("post_rst_done_pulses", ndone, 1);

        // Randomized bursts with a randomly throttled consumer.
        for (int r = 0; r < 25; r++) begin
            logic [8:0] rb;
            int         rl;
            int         rp;
            rb = 9'($urandom_range(511));
            rl = $urandom_range(40);
            rp = $urandom_range(100, 30);
            run_burst(rb, rl, rp, 0, 0, 0, 1500);
            check("rand_done_pulses", ndone, 1);
            check("rand_word_count", nwords, rl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_tx_stream_reader
`default_nettype wire
